button_debouncer: RTL

Synchronizes and debounces one raw mechanical push-button input for the Pong game. It produces a clean, glitch-free level on `Debounced`, which drives `InputPulse` of the falling-edge one-shot stage directly downstream. One instance is used per board button.

---
 rtl/button_debouncer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus four-state qualification FSM that turns a
// bouncing push-button level into one clean level per button.
module button_debouncer #(
  parameter int STABLE_COUNT = 1000000,
  parameter int COUNT_WIDTH  = 20
) (
  input  logic CLOCK,
  input  logic Reset,
  input  logic RawButton,
  output logic Debounced,
  output logic Busy
);

  typedef enum logic [1:0] {
    STABLE0,
    PENDING1,
    STABLE1,
    PENDING0
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] TERM =
    COUNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE  =
    COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] ZERO =
    '0;

  logic                   sync1;
  logic                   sync2;
  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_nxt;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= RawButton;
      sync2 <= sync1;
    end
  end

  // State and stability counter registers; reset drops any partial count.
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      state <= STABLE0;
      count <= ZERO;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next state: a candidate level must persist for STABLE_COUNT
  // observations in a row; any disagreement throws the run away.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    unique case (state)
      STABLE0: begin
        count_nxt = ZERO;
        if (sync2) begin
          state_nxt = PENDING1;
          count_nxt = ONE;
        end
      end
      PENDING1: begin
        if (!sync2) begin
          state_nxt = STABLE0;
          count_nxt = ZERO;
        end else if (count == TERM) begin
          state_nxt = STABLE1;
          count_nxt = ZERO;
        end else begin
          count_nxt = count + ONE;
        end
      end
      STABLE1: begin
        count_nxt = ZERO;
        if (!sync2) begin
          state_nxt = PENDING0;
          count_nxt = ONE;
        end
      end
      PENDING0: begin
        if (sync2) begin
          state_nxt = STABLE1;
          count_nxt = ZERO;
        end else if (count == TERM) begin
          state_nxt = STABLE0;
          count_nxt = ZERO;
        end else begin
          count_nxt = count + ONE;
        end
      end
      default: begin
        state_nxt = STABLE0;
        count_nxt = ZERO;
      end
    endcase
  end

  // Outputs come from the registered state only.
  always_comb begin
    Debounced = 1'b0;
    Busy      = 1'b0;
    unique case (state)
      STABLE0:  begin
        Debounced = 1'b0;
        Busy      = 1'b0;
      end
      PENDING1: begin
        Debounced = 1'b0;
        Busy      = 1'b1;
      end
      STABLE1:  begin
        Debounced = 1'b1;
        Busy      = 1'b0;
      end
      PENDING0: begin
        Debounced = 1'b1;
        Busy      = 1'b1;
      end
      default: begin
        Debounced = 1'b0;
        Busy      = 1'b0;
      end
    endcase
  end

endmodule
